// File: rtl/m_lsu.sv
// m_lsu: M-stage load/store initiator.
// Turns one pipeline memory access into a req/ack word-bus transaction and
// stalls the pipeline until the responder acks or the timeout expires.
// Optional feature: define LSU_ALIGN_CHECK_EN to fault misaligned w/h/hu
// accesses (FAULT state, lsu_exc pulse) instead of silently ignoring low bits.
module m_lsu #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned TO_W    = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        M_mem_en,
   input  logic        M_dwe,
   input  logic [2:0]  M_dm_sel,
   input  logic [31:0] M_addr,
   input  logic [31:0] M_wdata,
   input  logic [31:0] M_pc,
   output logic        lsu_stall,
   output logic [31:0] lsu_rdata,
   output logic        lsu_rvalid,
   output logic        lsu_exc,
   output logic        lsu_err,
   output logic [31:0] lsu_epc,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam logic [2:0] DM_W  = 3'd0;
   localparam logic [2:0] DM_H  = 3'd1;
   localparam logic [2:0] DM_B  = 3'd2;
   localparam logic [2:0] DM_HU = 3'd3;
   localparam logic [2:0] DM_BU = 3'd4;
   localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
`ifdef LSU_ALIGN_CHECK_EN
      , S_FAULT = 2'd3
`endif
   } state_t;

   state_t            state_q, state_d;
   logic              we_q;
   logic [31:0]       addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic [2:0]        sel_q;
   logic [1:0]        lo_q;
   logic [31:0]       pc_q;
   logic [31:0]       rdata_q;
   logic [TO_W-1:0]   cnt_q;
   logic              err_q;
   logic [31:0]       epc_q;

   logic [3:0]        be_c;
   logic [31:0]       wd_c;
   logic              noop_c;
   logic              mis_c;
   logic              timeout_c;
   logic [15:0]       half_c;
   logic [7:0]        byte_c;
   logic [31:0]       ext_c;

   // Byte enables, lane-replicated write data, no-op and misalignment decode
   always_comb begin
      be_c   = 4'b1111;
      wd_c   = M_wdata;
      noop_c = M_dwe && ((M_dm_sel == DM_HU) || (M_dm_sel == DM_BU) || (M_dm_sel > DM_BU));
      mis_c  = 1'b0;
      case (M_dm_sel)
         DM_W: begin
            be_c = 4'b1111;
            wd_c = M_wdata;
         end
         DM_H, DM_HU: begin
            be_c = 4'b0011 << {M_addr[1], 1'b0};
            wd_c = {2{M_wdata[15:0]}};
         end
         DM_B, DM_BU: begin
            be_c = 4'b0001 << M_addr[1:0];
            wd_c = {4{M_wdata[7:0]}};
         end
         default: ;
      endcase
      if (noop_c) begin
         be_c = 4'b0000;
      end
`ifdef LSU_ALIGN_CHECK_EN
      mis_c = ((M_dm_sel == DM_W) && (M_addr[1:0] != 2'b00)) ||
              (((M_dm_sel == DM_H) || (M_dm_sel == DM_HU)) && M_addr[0]);
`endif
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      timeout_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (M_mem_en) begin
               if (mis_c) begin
`ifdef LSU_ALIGN_CHECK_EN
                  state_d = S_FAULT;
`endif
               end else if (noop_c) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (bus_ack) begin
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = S_DONE;
               timeout_c = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Access latch, timeout counter, read-word capture and exception PC
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         lo_q    <= '0;
         pc_q    <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         epc_q   <= '0;
      end else begin
         if ((state_q == S_IDLE) && M_mem_en) begin
            we_q    <= M_dwe;
            addr_q  <= {M_addr[31:2], 2'b00};
            be_q    <= be_c;
            wdata_q <= wd_c;
            sel_q   <= M_dm_sel;
            lo_q    <= M_addr[1:0];
            pc_q    <= M_pc;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            if (mis_c) begin
               epc_q <= M_pc;
            end
         end
         if (state_q == S_REQ) begin
            cnt_q <= cnt_q + 1'b1;
            if (bus_ack) begin
               rdata_q <= bus_rdata;
            end else if (timeout_c) begin
               err_q <= 1'b1;
               epc_q <= pc_q;
            end
         end
      end
   end

   // Load lane extraction and sign/zero extension from the captured word
   always_comb begin
      half_c = lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (lo_q)
         2'd0:    byte_c = rdata_q[7:0];
         2'd1:    byte_c = rdata_q[15:8];
         2'd2:    byte_c = rdata_q[23:16];
         default: byte_c = rdata_q[31:24];
      endcase
      ext_c = rdata_q;
      case (sel_q)
         DM_H:    ext_c = {{16{half_c[15]}}, half_c};
         DM_HU:   ext_c = {16'h0000, half_c};
         DM_B:    ext_c = {{24{byte_c[7]}}, byte_c};
         DM_BU:   ext_c = {24'h000000, byte_c};
         default: ext_c = rdata_q;
      endcase
   end

   assign bus_req    = (state_q == S_REQ);
   assign bus_we     = we_q;
   assign bus_addr   = addr_q;
   assign bus_be     = be_q;
   assign bus_wdata  = wdata_q;
   assign lsu_rvalid = (state_q == S_DONE) && !we_q && !err_q;
   assign lsu_err    = (state_q == S_DONE) && err_q;
   assign lsu_rdata  = lsu_rvalid ? ext_c : 32'h0000_0000;
   assign lsu_epc    = epc_q;
`ifdef LSU_ALIGN_CHECK_EN
   assign lsu_exc    = (state_q == S_FAULT);
   assign lsu_stall  = M_mem_en && (state_q != S_DONE) && (state_q != S_FAULT);
`else
   assign lsu_exc    = 1'b0;
   assign lsu_stall  = M_mem_en && (state_q != S_DONE);
`endif

endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: scoreboard bench for m_lsu. Expected bus transactions and load
// results are queued when an access is issued and checked when the DUT
// raises bus_req / completes the access.
module tb_m_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        M_mem_en;
   logic        M_dwe;
   logic [2:0]  M_dm_sel;
   logic [31:0] M_addr;
   logic [31:0] M_wdata;
   logic [31:0] M_pc;
   logic        lsu_stall;
   logic [31:0] lsu_rdata;
   logic        lsu_rvalid;
   logic        lsu_exc;
   logic        lsu_err;
   logic [31:0] lsu_epc;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } bus_t;

   bus_t        bus_q[$];
   logic [31:0] rd_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;

   m_lsu #(.TIMEOUT(64), .TO_W(7)) dut (
      .clk(clk), .reset(reset),
      .M_mem_en(M_mem_en), .M_dwe(M_dwe), .M_dm_sel(M_dm_sel),
      .M_addr(M_addr), .M_wdata(M_wdata), .M_pc(M_pc),
      .lsu_stall(lsu_stall), .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
      .lsu_exc(lsu_exc), .lsu_err(lsu_err), .lsu_epc(lsu_epc),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic idle();
      @(negedge clk);
      M_mem_en = 1'b0;
      M_dwe    = 1'b0;
      bus_ack  = 1'b0;
   endtask

   // One access with a responder acking after ack_lat extra REQ cycles
   task automatic access(input string tag, input logic we, input logic [2:0] sel,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] rd,
                         input logic [31:0] exp_rd, input int ack_lat);
      bus_t eb;
      bus_t ob;
      int   stalls;
      int   reqs;
      bit   done;
      eb.we = we; eb.addr = exp_addr; eb.be = exp_be; eb.wd = exp_wd;
      bus_q.push_back(eb);
      if (!we) rd_q.push_back(exp_rd);
      @(negedge clk);
      M_mem_en = 1'b1; M_dwe = we; M_dm_sel = sel; M_addr = addr; M_wdata = wd; M_pc = pc;
      #1;
      stalls = lsu_stall ? 1 : 0;
      reqs   = 0;
      done   = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!lsu_stall) begin
            done = 1'b1;
            break;
         end
         stalls++;
         if (bus_req) begin
            if (reqs == 0) begin
               if (bus_q.size() == 0) begin
                  n_fail++; n_cmp++;
                  $display("FAIL %s bus_q: got unexpected bus_req, want empty scoreboard", tag);
               end else begin
                  ob = '{we: bus_we, addr: bus_addr, be: bus_be, wd: bus_wdata};
                  eb = bus_q.pop_front();
                  if (ob.we !== eb.we) begin n_fail++; $display("FAIL %s bus_we: got %b want %b", tag, ob.we, eb.we); end
                  n_cmp++;
                  if (ob.addr !== eb.addr) begin n_fail++; $display("FAIL %s bus_addr: got %h want %h", tag, ob.addr, eb.addr); end
                  n_cmp++;
                  if (ob.be !== eb.be) begin n_fail++; $display("FAIL %s bus_be: got %b want %b", tag, ob.be, eb.be); end
                  n_cmp++;
                  if (ob.wd !== eb.wd) begin n_fail++; $display("FAIL %s bus_wdata: got %h want %h", tag, ob.wd, eb.wd); end
                  n_cmp++;
               end
            end
            bus_ack   = (reqs == ack_lat);
            bus_rdata = rd;
            reqs++;
         end
      end
      bus_ack = 1'b0;
      if (!done) begin
         n_fail++; n_cmp++;
         $display("FAIL %s done: stall still high after 200 cycles, want release", tag);
      end else begin
         if (reqs == 0) begin n_fail++; $display("FAIL %s req_seen: got 0 bus_req cycles, want >0", tag); end
         n_cmp++;
         if (stalls !== ack_lat + 2) begin n_fail++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, ack_lat + 2); end
         n_cmp++;
         if (bus_req !== 1'b0) begin n_fail++; $display("FAIL %s done_req: got %b want 0", tag, bus_req); end
         n_cmp++;
         if (lsu_err !== 1'b0) begin n_fail++; $display("FAIL %s done_err: got %b want 0", tag, lsu_err); end
         n_cmp++;
         if (lsu_rvalid !== !we) begin n_fail++; $display("FAIL %s rvalid: got %b want %b", tag, lsu_rvalid, !we); end
         n_cmp++;
         if (!we && rd_q.size() != 0) begin
            eb.wd = rd_q.pop_front();
            if (lsu_rdata !== eb.wd) begin n_fail++; $display("FAIL %s rdata: got %h want %h", tag, lsu_rdata, eb.wd); end
            n_cmp++;
         end else if (we && lsu_rdata !== 32'h0) begin
            n_fail++; n_cmp++;
            $display("FAIL %s store_rdata: got %h want 00000000", tag, lsu_rdata);
         end else begin
            n_cmp++;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; M_mem_en = 1'b0; M_dwe = 1'b0; M_dm_sel = 3'd0;
      M_addr = '0; M_wdata = '0; M_pc = '0; bus_ack = 1'b0; bus_rdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus_req); end
      n_cmp++;
      if (lsu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", lsu_stall); end
      n_cmp++;
      if ({lsu_rvalid, lsu_err, lsu_exc} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses: got %b want 000", {lsu_rvalid, lsu_err, lsu_exc}); end
      n_cmp++;
      if (lsu_epc !== 32'h0) begin n_fail++; $display("FAIL rst_epc: got %h want 0", lsu_epc); end
      n_cmp++;
      if ({bus_we, bus_be, bus_addr, bus_wdata, lsu_rdata} !== '0) begin
         n_fail++; $display("FAIL rst_bus: got we=%b be=%b addr=%h wd=%h rd=%h want all 0", bus_we, bus_be, bus_addr, bus_wdata, lsu_rdata);
      end
      n_cmp++;
   endtask

   task automatic test_store();
      access("sw", 1'b1, 3'd0, 32'h10, 32'h12345678, 32'h1000, 32'h10, 4'b1111, 32'h12345678, 32'h0, 32'h0, 0);
      access("sh", 1'b1, 3'd1, 32'h2, 32'h5555BEEF, 32'h1004, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0, 32'h0, 1);
      access("sb1", 1'b1, 3'd2, 32'h41, 32'h000000C3, 32'h1008, 32'h40, 4'b0010, 32'hC3C3C3C3, 32'h0, 32'h0, 0);
      idle();
   endtask

   task automatic test_back_to_back();
      access("sb", 1'b1, 3'd2, 32'h13, 32'h000000AB, 32'h2000, 32'h10, 4'b1000, 32'hABABABAB, 32'h0, 32'h0, 0);
      access("lb", 1'b0, 3'd2, 32'h13, 32'h0, 32'h2004, 32'h10, 4'b1000, 32'h0, 32'hAB000000, 32'hFFFFFFAB, 0);
      access("lbu", 1'b0, 3'd4, 32'h13, 32'h0, 32'h2008, 32'h10, 4'b1000, 32'h0, 32'hAB000000, 32'h000000AB, 0);
      idle();
   endtask

   task automatic test_load();
      access("lh", 1'b0, 3'd1, 32'h22, 32'h0, 32'h2100, 32'h20, 4'b1100, 32'h0, 32'h80010000, 32'hFFFF8001, 0);
      access("lhu", 1'b0, 3'd3, 32'h22, 32'h0, 32'h2104, 32'h20, 4'b1100, 32'h0, 32'h80010000, 32'h00008001, 2);
      access("lh0", 1'b0, 3'd1, 32'h20, 32'h0, 32'h2108, 32'h20, 4'b0011, 32'h0, 32'h12347FFE, 32'h00007FFE, 0);
      access("lb1", 1'b0, 3'd2, 32'h31, 32'h0, 32'h210C, 32'h30, 4'b0010, 32'h0, 32'h00008000, 32'hFFFFFF80, 0);
      access("lw", 1'b0, 3'd0, 32'h8, 32'h0, 32'h2110, 32'h8, 4'b1111, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 3);
      idle();
   endtask

   task automatic test_noop_store();
      @(negedge clk);
      M_mem_en = 1'b1; M_dwe = 1'b1; M_dm_sel = 3'd3; M_addr = 32'h20; M_wdata = 32'hFFFF; M_pc = 32'h2200;
      #1;
      if (lsu_stall !== 1'b1) begin n_fail++; $display("FAIL noop_stallN: got %b want 1", lsu_stall); end
      n_cmp++;
      @(negedge clk);
      if ({lsu_stall, bus_req, lsu_rvalid, lsu_err} !== 4'b0000) begin
         n_fail++; $display("FAIL noop_done: got stall/req/rv/err=%b want 0000", {lsu_stall, bus_req, lsu_rvalid, lsu_err});
      end
      n_cmp++;
      idle();
      if (bus_req !== 1'b0) begin n_fail++; $display("FAIL noop_req: got %b want 0", bus_req); end
      n_cmp++;
   endtask

   task automatic test_timeout();
      int  reqs;
      bit  done;
      bus_t eb;
      eb.we = 1'b0; eb.addr = 32'h20; eb.be = 4'b0011; eb.wd = 32'h0;
      bus_q.push_back(eb);
      @(negedge clk);
      M_mem_en = 1'b1; M_dwe = 1'b0; M_dm_sel = 3'd1; M_addr = 32'h20; M_wdata = 32'h0; M_pc = 32'h5000;
      bus_ack = 1'b0;
      reqs = 0; done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!lsu_stall) begin done = 1'b1; break; end
         if (bus_req) begin
            if (reqs == 0 && bus_q.size() != 0) begin
               eb = bus_q.pop_front();
               if (bus_be !== eb.be) begin n_fail++; $display("FAIL to_be: got %b want %b", bus_be, eb.be); end
               n_cmp++;
            end
            reqs++;
         end
      end
      if (!done) begin
         n_fail++; n_cmp++;
         $display("FAIL to_release: stall still high after 200 cycles, want release");
      end else begin
         if (reqs !== 64) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 64", reqs); end
         n_cmp++;
         if (lsu_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", lsu_err); end
         n_cmp++;
         if (lsu_epc !== 32'h5000) begin n_fail++; $display("FAIL to_epc: got %h want 00005000", lsu_epc); end
         n_cmp++;
         if ({lsu_rvalid, bus_req} !== 2'b00) begin n_fail++; $display("FAIL to_rv_req: got %b want 00", {lsu_rvalid, bus_req}); end
         n_cmp++;
         if (lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", lsu_rdata); end
         n_cmp++;
      end
      idle();
      if (lsu_err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse: got %b want 0", lsu_err); end
      n_cmp++;
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      M_mem_en = 1'b1; M_dwe = 1'b0; M_dm_sel = 3'd0; M_addr = 32'h40; M_pc = 32'h6000;
      @(negedge clk);
      if (bus_req !== 1'b1) begin n_fail++; $display("FAIL ra_req1: got %b want 1", bus_req); end
      n_cmp++;
      @(negedge clk);
      reset = 1'b1; M_mem_en = 1'b0;
      @(negedge clk);
      if (bus_req !== 1'b0) begin n_fail++; $display("FAIL ra_req_after_reset: got %b want 0", bus_req); end
      n_cmp++;
      reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus_ack = 1'b0;
         if ({bus_req, lsu_rvalid, lsu_err} !== 3'b000) begin
            n_fail++; $display("FAIL ra_quiet%0d: got req/rv/err=%b want 000", i, {bus_req, lsu_rvalid, lsu_err});
         end
         n_cmp++;
      end
   endtask

   task automatic test_align();
`ifdef LSU_ALIGN_CHECK_EN
      @(negedge clk);
      M_mem_en = 1'b1; M_dwe = 1'b0; M_dm_sel = 3'd0; M_addr = 32'h11; M_pc = 32'h3000;
      @(negedge clk);
      if ({bus_req, lsu_exc, lsu_stall} !== 3'b010) begin
         n_fail++; $display("FAIL al_fault: got req/exc/stall=%b want 010", {bus_req, lsu_exc, lsu_stall});
      end
      n_cmp++;
      if (lsu_epc !== 32'h3000) begin n_fail++; $display("FAIL al_epc: got %h want 00003000", lsu_epc); end
      n_cmp++;
      idle();
      if ({bus_req, lsu_exc} !== 2'b00) begin n_fail++; $display("FAIL al_pulse: got req/exc=%b want 00", {bus_req, lsu_exc}); end
      n_cmp++;
`else
      access("lw_mis", 1'b0, 3'd0, 32'h11, 32'h0, 32'h3000, 32'h10, 4'b1111, 32'h0, 32'h11223344, 32'h11223344, 0);
      idle();
      if (lsu_exc !== 1'b0) begin n_fail++; $display("FAIL al_exc: got %b want 0", lsu_exc); end
      n_cmp++;
`endif
   endtask

   initial begin
      test_reset();
      test_store();
      test_back_to_back();
      test_load();
      test_noop_store();
      test_timeout();
      test_reset_abort();
      test_align();
      if (bus_q.size() != 0 || rd_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d bus / %0d rdata left, want 0", bus_q.size(), rd_q.size());
      end
      n_cmp++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
